// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver with configurable parity and stop
// bits, 3-sample majority voting, an input synchroniser and a one-entry
// valid/ready output buffer that flags overruns.
module uart_rx_cfg #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESCALE_W  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic                  RX_READY,
  output logic [DATA_WIDTH-1:0] P_data,
  output logic                  RX_VALID,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  ovr_err,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [PRESCALE_W-1:0] ONE_P    = PRESCALE_W'(1);
  localparam logic [3:0]            LAST_BIT = 4'(DATA_WIDTH - 1);

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    rx_s;

  logic [PRESCALE_W-1:0]   edge_cnt;
  logic [3:0]              bit_cnt;
  logic [PRESCALE_W-1:0]   presc_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic                    stop2_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [1:0]              samp_q;
  logic                    par_bad_q;
  logic                    stp_bad_q;

  logic [PRESCALE_W-1:0]   half;
  logic                    is_samp_a;
  logic                    is_samp_b;
  logic                    is_dec;
  logic                    is_wrap;
  logic                    maj;
  logic                    last_stop;
  logic                    frame_done;

  // Sampling points are fixed relative to the captured prescale so a frame
  // keeps its timing even if PRESCALE moves underneath it.
  assign half      = presc_q >> 1;
  assign is_samp_a = (edge_cnt == half - ONE_P);
  assign is_samp_b = (edge_cnt == half);
  assign is_dec    = (edge_cnt == half + ONE_P);
  assign is_wrap   = (edge_cnt == presc_q - ONE_P);

  // Third vote is the live sample at the decision point.
  assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

  assign last_stop = stop2_q ? (bit_cnt == 4'd1) : 1'b1;
  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign busy      = (state_q != IDLE);

  // Input synchroniser; resets to the idle line level so reset never looks
  // like a start edge.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (RST) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], RX_IN};
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and frame-completion strobe.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        if (is_dec && maj) state_d = IDLE;  // start glitch
        else if (is_wrap)  state_d = DATA;
      end
      DATA: begin
        if (is_wrap && (bit_cnt == LAST_BIT)) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (is_wrap) state_d = STOP;
      end
      STOP: begin
        // Completing at the decision point lets a start edge that follows
        // the last stop bit's centre be tracked without losing a cycle.
        if (is_dec && last_stop) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Edge and bit counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (state_q == IDLE || state_d == IDLE) edge_cnt <= '0;
      else if (is_wrap)                       edge_cnt <= '0;
      else                                    edge_cnt <= edge_cnt + ONE_P;

      if (state_d != state_q)                 bit_cnt <= '0;
      else if (is_wrap && state_q != IDLE)    bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Per-frame configuration capture, bit sampling and error accumulation.
  always_ff @(posedge CLK) begin
    // NOTE: datapath registers are reset alongside control so reset leaves
    // the block in one fully defined state, not just a defined FSM.
    if (RST) begin
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
      data_q    <= '0;
      samp_q    <= '0;
      par_bad_q <= 1'b0;
      stp_bad_q <= 1'b0;
    end else begin
      if (state_q == IDLE && !rx_s) begin
        presc_q   <= PRESCALE;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        stop2_q   <= STOP2;
        par_bad_q <= 1'b0;
        stp_bad_q <= 1'b0;
      end

      if (state_q != IDLE) begin
        if (is_samp_a) samp_q[0] <= rx_s;
        if (is_samp_b) samp_q[1] <= rx_s;
      end

      if (is_dec) begin
        unique case (state_q)
          // LSB arrives first, so shifting right leaves it in bit 0.
          DATA:    data_q    <= {maj, data_q[DATA_WIDTH-1:1]};
          PARITY:  par_bad_q <= ((^data_q) ^ par_typ_q) != maj;
          STOP:    if (!maj) stp_bad_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // One-entry output buffer: a completing frame loads if the slot is free
  // or being drained this cycle, otherwise it is dropped with ovr_err.
  always_ff @(posedge CLK) begin
    if (RST) begin
      P_data   <= '0;
      RX_VALID <= 1'b0;
      par_err  <= 1'b0;
      stp_err  <= 1'b0;
      ovr_err  <= 1'b0;
    end else begin
      ovr_err <= 1'b0;
      if (frame_done) begin
        if (!RX_VALID || RX_READY) begin
          P_data   <= data_q;
          par_err  <= par_bad_q & par_en_q;
          stp_err  <= stp_bad_q | ~maj;
          RX_VALID <= 1'b1;
        end else begin
          ovr_err  <= 1'b1;
        end
      end else if (RX_VALID && RX_READY) begin
        RX_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed and randomized frames against a word-level
// scoreboard of expected data and error flags.
module tb_uart_rx_cfg;

  localparam int DW = 8;
  localparam int PW = 6;
  localparam int SS = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          pe;
    logic          se;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic [PW-1:0] PRESCALE;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          STOP2;
  logic          RX_READY;
  logic [DW-1:0] P_data;
  logic          RX_VALID;
  logic          par_err;
  logic          stp_err;
  logic          ovr_err;
  logic          busy;

  int   n_checks = 0;
  int   n_errors = 0;
  int   acc_cnt  = 0;
  int   ovr_cnt  = 0;
  int   exp_ovr  = 0;
  bit   abort    = 1'b0;
  time  last_rise;
  time  t_last_stop;
  exp_t exp_q[$];

  uart_rx_cfg #(.DATA_WIDTH(DW), .PRESCALE_W(PW), .SYNC_STAGES(SS)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .RX_READY(RX_READY),
    .P_data(P_data), .RX_VALID(RX_VALID), .par_err(par_err),
    .stp_err(stp_err), .ovr_err(ovr_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      RX_IN = 1'b1;
    end
  endtask

  // Drive one frame; spike_idx >= 0 inverts one cycle of that data bit.
  task automatic send_frame(input logic [DW-1:0] d, input int p, input bit pen,
                            input bit ptyp, input bit st2, input bit pflip,
                            input bit [1:0] stopv, input int spike_idx,
                            input int spike_off, input int last_len, input bit push);
    logic bits[$];
    exp_t e;
    int   len;
    PRESCALE = PW'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    STOP2    = st2;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pen) bits.push_back((^d) ^ ptyp ^ pflip);
    bits.push_back(stopv[0]);
    if (st2) bits.push_back(stopv[1]);
    if (push) begin
      e.d  = d;
      e.pe = pen & pflip;
      e.se = ~stopv[0] | (st2 & ~stopv[1]);
      exp_q.push_back(e);
    end
    for (int i = 0; i < bits.size(); i++) begin
      len = (i == bits.size() - 1) ? last_len : p;
      for (int c = 0; c < len; c++) begin
        tick();
        if (abort) begin
          RX_IN = 1'b1;
          return;
        end
        if (i == bits.size() - 1 && c == 0) t_last_stop = $time - 1;
        RX_IN = (spike_idx >= 0 && i == spike_idx + 1 && c == spike_off) ? ~bits[i] : bits[i];
      end
    end
  endtask

  // Consumer-side monitor: scoreboards every accepted word.
  initial begin
    exp_t e;
    logic prev_valid = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev_valid = 1'b0;
      end else begin
        if (RX_VALID && !prev_valid) last_rise = $time;
        prev_valid = RX_VALID;
        if (ovr_err) ovr_cnt++;
        if (RX_VALID && RX_READY) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            check("spurious_word", 32'(P_data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("word_data", 32'(P_data), 32'(e.d));
            check("word_par_err", 32'(par_err), 32'(e.pe));
            check("word_stp_err", 32'(stp_err), 32'(e.se));
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    int a0, o0, p, gap, last_len, sp_idx, sp_off;
    bit pen, ptyp, st2, pflip;
    bit [1:0] stopv;
    logic [DW-1:0] d;

    RST = 1'b1; RX_IN = 1'b1; RX_READY = 1'b1;
    PRESCALE = PW'(8); PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    repeat (3) tick();
    @(negedge CLK);
    check("rst_P_data", 32'(P_data), 32'h0);
    check("rst_RX_VALID", 32'(RX_VALID), 32'h0);
    check("rst_flags", 32'({par_err, stp_err, ovr_err}), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    tick();
    RST = 1'b0;
    idle(4);

    // Basic frame, latency and busy.
    a0 = acc_cnt;
    fork
      send_frame(8'hA5, 8, 0, 0, 0, 0, 2'b11, -1, 0, 8, 1);
      begin
        repeat (20) tick();
        @(negedge CLK);
        check("busy_mid_frame", 32'(busy), 32'h1);
      end
    join
    idle(12);
    check("valid_latency", 32'(last_rise - t_last_stop), 32'((SS + 8 / 2 + 3) * 10 + 5));
    check("basic_accepts", 32'(acc_cnt - a0), 32'h1);
    @(negedge CLK);
    check("basic_idle_after", 32'({busy, RX_VALID}), 32'h0);

    // Parity: correct even, wrong even, correct odd.
    send_frame(8'h37, 16, 1, 0, 0, 0, 2'b11, -1, 0, 16, 1);
    idle(20);
    send_frame(8'h37, 16, 1, 0, 0, 1, 2'b11, -1, 0, 16, 1);
    idle(20);
    send_frame(8'h37, 16, 1, 1, 0, 0, 2'b11, -1, 0, 16, 1);
    idle(20);

    // Two stop bits with the second bad, then an immediate back-to-back start.
    send_frame(8'h5C, 16, 0, 0, 1, 0, 2'b01, -1, 0, 16 / 2 + 3, 1);
    send_frame(8'h9B, 16, 0, 0, 1, 0, 2'b11, -1, 0, 16, 1);
    idle(24);

    // Overrun with consumer stalled.
    RX_READY = 1'b0;
    send_frame(8'h11, 8, 0, 0, 0, 0, 2'b11, -1, 0, 8, 1);
    idle(12);
    @(negedge CLK);
    check("ovr_first_held", 32'({RX_VALID, P_data}), 32'({1'b1, 8'h11}));
    o0 = ovr_cnt;
    send_frame(8'h22, 8, 0, 0, 0, 0, 2'b11, -1, 0, 8, 0);
    exp_ovr++;
    idle(12);
    check("ovr_pulse_count", 32'(ovr_cnt - o0), 32'h1);
    @(negedge CLK);
    check("ovr_buffer_kept", 32'({RX_VALID, P_data}), 32'({1'b1, 8'h11}));
    tick();
    RX_READY = 1'b1;
    tick();
    @(negedge CLK);
    check("ovr_valid_drop", 32'(RX_VALID), 32'h0);

    // Start glitch of two cycles.
    PRESCALE = PW'(16);
    a0 = acc_cnt; o0 = ovr_cnt;
    tick(); RX_IN = 1'b0;
    tick();
    tick(); RX_IN = 1'b1;
    repeat (3) tick();
    @(negedge CLK);
    check("glitch_start_busy", 32'(busy), 32'h1);
    repeat (24) tick();
    @(negedge CLK);
    check("glitch_back_idle", 32'(busy), 32'h0);
    check("glitch_no_word", 32'(acc_cnt - a0), 32'h0);
    check("glitch_no_ovr", 32'(ovr_cnt - o0), 32'h0);

    // Single-cycle spikes at the centre sample of a data bit.
    send_frame(8'hF0, 16, 0, 0, 0, 0, 2'b11, 2, 16 / 2 + 1, 16, 1);
    idle(20);
    send_frame(8'hF0, 16, 0, 0, 0, 0, 2'b11, 5, 16 / 2 + 1, 16, 1);
    idle(20);

    // Reset mid-DATA while a word is held.
    RX_READY = 1'b0;
    send_frame(8'h5A, 8, 0, 0, 0, 0, 2'b11, -1, 0, 8, 1);
    idle(12);
    fork
      send_frame(8'h99, 8, 0, 0, 0, 0, 2'b11, -1, 0, 8, 0);
      begin
        repeat (24) tick();
        @(negedge CLK);
        check("rst_pre_busy", 32'({busy, RX_VALID}), 32'h3);
        tick();
        RST = 1'b1;
        abort = 1'b1;
        tick();
        RST = 1'b0;
      end
    join
    @(negedge CLK);
    check("midrst_outputs", 32'({RX_VALID, par_err, stp_err, ovr_err, busy}), 32'h0);
    check("midrst_P_data", 32'(P_data), 32'h0);
    exp_q.delete();
    abort = 1'b0;
    idle(10);
    RX_READY = 1'b1;
    a0 = acc_cnt;
    send_frame(8'hC3, 8, 0, 0, 0, 0, 2'b11, -1, 0, 8, 1);
    idle(12);
    check("post_rst_accept", 32'(acc_cnt - a0), 32'h1);

    // PRESCALE change mid-frame must not disturb the frame in flight.
    fork
      send_frame(8'h6E, 16, 0, 0, 0, 0, 2'b11, -1, 0, 16, 1);
      begin
        repeat (40) tick();
        PRESCALE = PW'(10);
      end
    join
    idle(24);

    // Randomized frames.
    for (int n = 0; n < 30; n++) begin
      p      = 2 * $urandom_range(4, 31);
      d      = DW'($urandom);
      pen    = 1'($urandom);
      ptyp   = 1'($urandom);
      st2    = 1'($urandom);
      pflip  = ($urandom_range(0, 3) == 0);
      stopv  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      sp_idx = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, DW - 1));
      sp_off = $urandom_range(0, p - 1);
      last_len = ($urandom_range(0, 2) == 0) ? (p / 2 + 3) : p;
      send_frame(d, p, pen, ptyp, st2, pflip, stopv, sp_idx, sp_off, last_len, 1);
      if (last_len != p)                            gap = 0;
      else if (!(st2 ? stopv[1] : stopv[0]))        gap = p + 8;
      else                                          gap = $urandom_range(0, 3);
      idle(gap);
    end
    idle(80);

    for (int w = 0; w < 2000 && exp_q.size() != 0; w++) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    check("total_overruns", 32'(ovr_cnt), 32'(exp_ovr));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
